alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Execute->writeback stage directly downstream of the ALU. Buffers ALU result/flag
//  packets in a 2-entry in-order queue and holds the architectural NZCV register.
//  Evaluates each packet's condition code against NZCV, then retires it: writes
//  the register file (with ack handshake), updates NZCV, or squashes it.
// PARAMETERS
//  DATA_W      32  result / register-file data width
//  REG_ADDR_W  4   register index width (16 GPRs)
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous reset, active-low
//  in_valid      in   1           packet from ALU valid
//  in_ready      out  1           stage can accept packet
//  in_result     in   DATA_W      ALU result
//  in_flags      in   4           ALU flags {N, nonzero, C, V} (bit2 = result nonzero)
//  in_dest       in   REG_ADDR_W  destination register
//  in_wr_en      in   1           packet writes in_dest
//  in_set_flags  in   1           packet updates NZCV
//  in_cond       in   4           condition code
//  rf_wr_en      out  1           register-file write request
//  rf_wr_addr    out  REG_ADDR_W  write address
//  rf_wr_data    out  DATA_W      write data
//  rf_wr_ack     in   1           register file accepted write this cycle
//  nzcv          out  4           architectural flags {N,Z,C,V}
//  retire_cnt    out  16          count of condition-passed retirements
// BEHAVIOUR
//  Reset (async, rst_n=0): queue emptied, nzcv=4'b0000, retire_cnt=0, rf_wr_en=0,
//   rf_wr_addr=0, rf_wr_data=0, in_ready=0 while rst_n low. Pending write dropped.
//  Queue: 2 entries, in order. in_ready = (count<2), not relaxed by same-cycle pop.
//   Push on in_valid&in_ready at clk edge. Push+pop same cycle: count unchanged.
//  Flag mapping at push: N=in_flags[3], Z=~in_flags[2], C=in_flags[1], V=in_flags[0].
//  Head evaluation (combinational on head entry and current nzcv register):
//   0 EQ Z | 1 NE ~Z | 2 CS C | 3 CC ~C | 4 MI N | 5 PL ~N | 6 VS V | 7 VC ~V
//   8 HI C&~Z | 9 LS ~C|Z | A GE N==V | B LT N!=V | C GT ~Z&(N==V) | D LE Z|(N!=V)
//   E AL 1 | F NV 0
//  Retire of head (per-cycle, one entry max):
//   - cond fail: SQUASH; pop this cycle, no rf write, nzcv and retire_cnt unchanged.
//   - cond pass, wr_en=0: pop this cycle; nzcv<=head flags if set_flags; cnt++.
//   - cond pass, wr_en=1: rf_wr_en=1 with head addr/data; pop only on rf_wr_ack;
//     nzcv update and cnt++ occur at that same edge. addr/data held stable until ack.
//  rf_wr_en/addr/data are combinational from head entry; addr/data = 0 when rf_wr_en=0.
//  rf_wr_ack ignored when rf_wr_en=0.
//  In-order flag dependence: entry 2 evaluates against nzcv after entry 1 retires
//   (no bypass within queue); next-cycle visibility.
//  Latency: packet pushed at edge t drives rf_wr_en in cycle t+1; full throughput
//   (1/cycle) with rf_wr_ack tied high.
//  retire_cnt: 16-bit, wraps 16'hFFFF->0. Squashes do not count.
//  Push into empty queue same cycle as reset release: ignored (in_ready=0).
// TESTING
//  1 Reset mid-stall: 1 write pending, ack=0, rst_n pulsed low -> rf_wr_en=0 at once,
//    nzcv=0, retire_cnt=0; after release in_ready=1, queue empty.
//  2 Push result=32'h5, dest=3, wr_en=1, set_flags=1, flags=4'b0100, cond=E, ack=1
//    -> cycle t+1 rf_wr_en=1 addr=3 data=5; then nzcv=0000, retire_cnt=1.
//  3 Push result=0, flags=4'b0000, set_flags=1, wr_en=0, AL -> nzcv=4'b0100; next
//    EQ(dest=1) writes; NE(dest=2) squashed: no rf_wr_en, retire_cnt +1 only for EQ.
//  4 ack=0 for 5 cycles, 3 back-to-back pushes A,B,C -> in_ready=0 after 2 accepted,
//    rf_wr_data=A stable; on acks writes appear A,B,C in order.
//  5 Set flags 4'b1101 (N=1,Z=0,C=0,V=1) -> GE writes, LT squashed, NV never writes,
//    HI squashed, LS writes.
//  6 65536 AL no-write packets -> retire_cnt wraps to 16'h0000; rf_wr_en never set.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry in-order packet queue, condition evaluation against
// the architectural NZCV register, and register-file write with ack handshake.
module alu_writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [3:0]            in_flags,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wr_en,
    input  logic                  in_set_flags,
    input  logic [3:0]            in_cond,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    input  logic                  rf_wr_ack,
    output logic [3:0]            nzcv,
    output logic [15:0]           retire_cnt
);

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [3:0]            flags;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wr_en;
        logic                  set_flags;
        cond_e                 cond;
    } entry_t;

    entry_t     q [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       ready_en;

    entry_t     head;
    logic       head_valid;
    logic       pass;
    logic       push;
    logic       pop;
    logic       retire;

    function automatic logic cond_pass(input cond_e cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            EQ:      return z;
            NE:      return ~z;
            CS:      return c;
            CC:      return ~c;
            MI:      return n;
            PL:      return ~n;
            VS:      return v;
            VC:      return ~v;
            HI:      return c & ~z;
            LS:      return ~c | z;
            GE:      return n == v;
            LT:      return n != v;
            GT:      return ~z & (n == v);
            LE:      return z | (n != v);
            AL:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ready_en holds in_ready low for the first cycle after reset release
    assign in_ready = ready_en && (count < 2'd2);
    assign push     = in_valid && in_ready;

    always_comb begin
        head       = q[rd_ptr];
        head_valid = (count != 2'd0);
        pass       = cond_pass(head.cond, nzcv);
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        pop        = 1'b0;
        retire     = 1'b0;
        if (head_valid) begin
            if (!pass) begin
                pop = 1'b1;
            end else if (!head.wr_en) begin
                pop    = 1'b1;
                retire = 1'b1;
            end else begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = head.dest;
                rf_wr_data = head.result;
                pop        = rf_wr_ack;
                retire     = rf_wr_ack;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q[0]       <= '0;
            q[1]       <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= '0;
            ready_en   <= 1'b0;
            nzcv       <= '0;
            retire_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                q[wr_ptr] <= '{result:    in_result,
                               flags:     {in_flags[3], ~in_flags[2], in_flags[1], in_flags[0]},
                               dest:      in_dest,
                               wr_en:     in_wr_en,
                               set_flags: in_set_flags,
                               cond:      cond_e'(in_cond)};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (!push && pop) count <= count - 2'd1;
            if (retire) begin
                retire_cnt <= retire_cnt + 16'd1;
                if (head.set_flags) nzcv <= head.flags;
            end
        end
    end

endmodule
